odo_power_seq: RTL
==================

# odo_power_seq

Parametrised power/enable sequencer for the odometer aging-sensor array. Supports N_CH ring-oscillator channels. It keeps stress power applied to the selected channels and runs a timed, per-channel measurement sequence on request. Each channel gets a settle delay, a fixed-length ROSC enable window and a completion pulse. It sits between the odometer control logic (START/MEAS_REQ) and the per-channel ROSC power switches and enables.

## Interface
- N_CH, default 4: number of ROSC channels (1..16).
- MEAS_W, default 8: width of the measurement-window length input.
- SETTLE_CYC, default 4: cycles between power-on and first ROSC enable (>=1).
- CLK  input  1  single clock; all state changes on rising edge.
- RESETn  input  1  asynchronous, active-low reset.
- START  input  1  level; high = stress mode requested.
- MEAS_REQ  input  1  level; measurement request, re-armed only after it goes low.
- CH_MASK  input  N_CH  channel select; latched on stress entry and on measurement start.
- MEAS_LEN  input  MEAS_W  ROSC enable window in cycles; latched at measurement start; value 0 treated as 1.
- EN_POWER_ROSC_STRESS  output  N_CH  per-channel power enable, registered.
- EN_ROSC  output  N_CH  per-channel oscillator enable, registered, one-hot or zero.
- MEAS_DONE  output  1  one-cycle pulse at end of a measurement sequence.
- BUSY  output  1  high in SETTLE, MEAS, GAP and DONE.

## Operation
- States: IDLE, STRESS, SETTLE, MEAS, GAP, DONE.
- IDLE:
  - All outputs 0.
  - START=1 -> STRESS, latch CH_MASK.
  - Armed MEAS_REQ=1 -> SETTLE.
  - MEAS_REQ takes priority when both are high.
- STRESS:
  - EN_POWER_ROSC_STRESS = latched mask; EN_ROSC = 0.
  - START=0 -> IDLE.
  - Armed MEAS_REQ=1 -> SETTLE.
- Measurement start (entry to SETTLE): latch CH_MASK and MEAS_LEN, clear arm flag, set channel pointer to lowest set mask bit.
- Latched mask == 0 -> go directly to DONE, with no power or ROSC activity.
- SETTLE:
  - Power = latched mask; count SETTLE_CYC cycles.
  - Then -> MEAS.
- MEAS:
  - EN_ROSC[ptr] = 1 for exactly max(MEAS_LEN,1) cycles.
  - Then -> GAP if a higher set mask bit remains, else -> DONE.
- GAP:
  - EN_ROSC = 0 for one cycle.
  - Advance ptr to next set bit, then -> MEAS. No re-settle.
- DONE:
  - MEAS_DONE = 1 for one cycle; EN_ROSC = 0.
  - Then START=1 -> STRESS, else -> IDLE.
- Arm flag:
  - Set after reset and whenever MEAS_REQ is sampled low.
  - MEAS_REQ held high does not retrigger.
  - MEAS_REQ during BUSY is ignored. It still re-arms if it drops low.
- START changes during BUSY do not abort the sequence. They only decide the DONE exit.
- CH_MASK changes during BUSY are ignored.
- Power stays on for all latched channels throughout SETTLE/MEAS/GAP/DONE.
- At most one EN_ROSC bit is high at any time.

## Timing
- Reset value of every output is 0; state IDLE; arm flag 1; counters 0.
- Reset assertion mid-sequence clears outputs asynchronously, with no MEAS_DONE.
- Outputs are registered. A request sampled at edge k gives:
  - power high after k;
  - EN_ROSC first high after edge k+SETTLE_CYC.
- Sequence length with m set channels: SETTLE_CYC + m*L + (m-1) + 1 cycles to MEAS_DONE, where L = max(MEAS_LEN,1).
- MEAS_DONE is followed by the STRESS/IDLE state on the next cycle. Power drops in that cycle if entering IDLE.
- Counters are MEAS_W and clog2(SETTLE_CYC+1) wide, saturating-free (reloaded per phase).

## Configuration
- ODO_SEQ_PARALLEL_EN defined:
  - MEAS enables all latched-mask bits of EN_ROSC simultaneously for L cycles.
  - No GAP state; DONE follows directly.
  - Sequence length is SETTLE_CYC + L + 1.
- Not defined: sequential one-hot operation as above.

## Structure
- Shared package odo_pkg holds:
  - the state enum type odo_seq_state_t;
  - SETTLE_CYC and MEAS_W defaults;
  - function next_set_bit(mask, ptr).
- One sub-module, odo_win_counter: loadable down-counter with a zero flag. It is instanced for the settle and measurement windows.

## Test plan
- N_CH=4, SETTLE_CYC=2, CH_MASK=4'b1010, MEAS_LEN=5, pulse MEAS_REQ from IDLE:
  - power=1010 for the whole sequence;
  - EN_ROSC=0010 for 5 cycles, 1 gap, 1000 for 5 cycles;
  - MEAS_DONE 14 cycles after the request edge;
  - return to IDLE with power 0.
- START=1, CH_MASK=4'b0111, then MEAS_REQ held high:
  - STRESS power=0111;
  - one sequence over ch0,1,2, then back to STRESS with power still 0111;
  - no second sequence until MEAS_REQ toggles low/high.
- CH_MASK=0, MEAS_REQ -> MEAS_DONE pulse the next cycle, EN_* never asserted.
- MEAS_LEN=0, mask 0001 -> EN_ROSC[0] high exactly 1 cycle.
- RESETn low during MEAS of the second channel -> all outputs 0 immediately, no MEAS_DONE, IDLE after release.
- With ODO_SEQ_PARALLEL_EN, mask 1111, MEAS_LEN=3 -> EN_ROSC=1111 for 3 cycles, MEAS_DONE after SETTLE_CYC+4 cycles.

Source files
------------

// File: rtl/odo_power_seq_pkg.sv
// rtl/odo_power_seq_pkg.sv - shared state type, defaults and mask helpers for the odometer power sequencer
package odo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STRESS = 3'd1,
        ST_SETTLE = 3'd2,
        ST_MEAS   = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5
    } odo_seq_state_t;

    localparam int ODO_N_CH_MAX       = 16;
    localparam int ODO_SETTLE_CYC_DEF = 4;
    localparam int ODO_MEAS_W_DEF     = 8;

    // Bit 4 set means "no such bit"; bits [3:0] carry the channel index otherwise.
    localparam logic [4:0] ODO_NO_BIT = 5'h10;

    function automatic logic [4:0] next_set_bit(input logic [15:0] mask, input logic [3:0] ptr);
        logic [4:0] r;
        r = ODO_NO_BIT;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i] && (i > int'(ptr))) begin
                r = 5'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [4:0] first_set_bit(input logic [15:0] mask);
        logic [4:0] r;
        r = ODO_NO_BIT;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                r = 5'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/odo_power_seq_if.sv
// rtl/odo_power_seq_if.sv - control/response bundle between odometer control logic and the power sequencer
interface odo_power_seq_if
    import odo_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int MEAS_W = ODO_MEAS_W_DEF
);
    logic              START;
    logic              MEAS_REQ;
    logic [N_CH-1:0]   CH_MASK;
    logic [MEAS_W-1:0] MEAS_LEN;
    logic [N_CH-1:0]   EN_POWER_ROSC_STRESS;
    logic [N_CH-1:0]   EN_ROSC;
    logic              MEAS_DONE;
    logic              BUSY;

    modport master (
        output START, MEAS_REQ, CH_MASK, MEAS_LEN,
        input  EN_POWER_ROSC_STRESS, EN_ROSC, MEAS_DONE, BUSY
    );

    modport slave (
        input  START, MEAS_REQ, CH_MASK, MEAS_LEN,
        output EN_POWER_ROSC_STRESS, EN_ROSC, MEAS_DONE, BUSY
    );
endinterface

// File: rtl/odo_power_seq_win_counter.sv
// rtl/odo_power_seq_win_counter.sv - loadable down-counter with zero flag for settle and measurement windows
module odo_win_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/odo_power_seq.sv
// rtl/odo_power_seq.sv - ROSC stress power / measurement sequencer; ODO_SEQ_PARALLEL_EN measures all channels at once
module odo_power_seq
    import odo_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int MEAS_W     = ODO_MEAS_W_DEF,
    parameter int SETTLE_CYC = ODO_SETTLE_CYC_DEF
) (
    input  logic            CLK,
    input  logic            RESETn,
    odo_power_seq_if.slave  bus
);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    odo_seq_state_t    state_q, state_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [MEAS_W-1:0] len_q, len_d;
    logic [3:0]        ptr_q, ptr_d;
    logic              arm_q, arm_d;

    logic              set_load, set_zero;
    logic              meas_load, meas_zero;
    logic [SET_W-1:0]  set_val;
    logic [MEAS_W-1:0] meas_val;

    logic [15:0]       mask16, req16;
    logic [4:0]        nxt_bit, first_bit;
    logic              meas_start;

    logic [N_CH-1:0]   power_q, power_d;
    logic [N_CH-1:0]   rosc_q, rosc_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    assign set_val  = SET_W'(SETTLE_CYC - 1);
    assign meas_val = len_q - MEAS_W'(1);

    odo_win_counter #(.W(SET_W)) u_settle_cnt (
        .clk      (CLK),
        .rst_n    (RESETn),
        .load     (set_load),
        .load_val (set_val),
        .zero     (set_zero)
    );

    odo_win_counter #(.W(MEAS_W)) u_meas_cnt (
        .clk      (CLK),
        .rst_n    (RESETn),
        .load     (meas_load),
        .load_val (meas_val),
        .zero     (meas_zero)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            len_q   <= '0;
            ptr_q   <= '0;
            arm_q   <= 1'b1;
            power_q <= '0;
            rosc_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            arm_q   <= arm_d;
            power_q <= power_d;
            rosc_q  <= rosc_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        len_d     = len_q;
        ptr_d     = ptr_q;
        set_load  = 1'b0;
        meas_load = 1'b0;

        mask16 = '0;
        mask16[N_CH-1:0] = mask_q;
        req16 = '0;
        req16[N_CH-1:0] = bus.CH_MASK;
        nxt_bit   = next_set_bit(mask16, ptr_q);
        first_bit = first_set_bit(req16);

        // Requests are only honoured from the two non-busy states.
        meas_start = arm_q && bus.MEAS_REQ &&
                     ((state_q == ST_IDLE) || (state_q == ST_STRESS));

        case (state_q)
            ST_IDLE: begin
                if (!meas_start && bus.START) begin
                    state_d = ST_STRESS;
                    mask_d  = bus.CH_MASK;
                end
            end
            ST_STRESS: begin
                if (!meas_start && !bus.START) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (set_zero) begin
                    state_d   = ST_MEAS;
                    meas_load = 1'b1;
                end
            end
            ST_MEAS: begin
                if (meas_zero) begin
`ifdef ODO_SEQ_PARALLEL_EN
                    state_d = ST_DONE;
`else
                    state_d = nxt_bit[4] ? ST_DONE : ST_GAP;
`endif
                end
            end
            ST_GAP: begin
                state_d   = ST_MEAS;
                ptr_d     = nxt_bit[3:0];
                meas_load = 1'b1;
            end
            ST_DONE: begin
                state_d = bus.START ? ST_STRESS : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (meas_start) begin
            mask_d   = bus.CH_MASK;
            len_d    = (bus.MEAS_LEN == '0) ? MEAS_W'(1) : bus.MEAS_LEN;
            ptr_d    = first_bit[3:0];
            set_load = 1'b1;
            state_d  = (bus.CH_MASK == '0) ? ST_DONE : ST_SETTLE;
        end

        if (meas_start) begin
            arm_d = 1'b0;
        end else if (!bus.MEAS_REQ) begin
            arm_d = 1'b1;
        end else begin
            arm_d = arm_q;
        end

        // Outputs are decoded from the next state so they line up with it after the edge.
        power_d = (state_d != ST_IDLE) ? mask_d : '0;
        rosc_d  = '0;
        if (state_d == ST_MEAS) begin
`ifdef ODO_SEQ_PARALLEL_EN
            rosc_d = mask_d;
`else
            for (int i = 0; i < N_CH; i++) begin
                rosc_d[i] = (int'(ptr_d) == i);
            end
`endif
        end
        done_d = (state_d == ST_DONE);
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_MEAS) ||
                 (state_d == ST_GAP)    || (state_d == ST_DONE);
    end

    assign bus.EN_POWER_ROSC_STRESS = power_q;
    assign bus.EN_ROSC              = rosc_q;
    assign bus.MEAS_DONE            = done_q;
    assign bus.BUSY                 = busy_q;

endmodule
